alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit ALU_OP code produced by the ALU control decoder, plus two operands, and returns a registered result.
- Valid/ready handshake on both sides, so the pipeline can stall.
- Logic and arithmetic ops complete in 1 cycle.
- Shifts run iteratively, 1 bit per cycle, unless the fast-shift option is compiled in.

---
 rtl/alu_exec_unit.sv | 175 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Execute-stage ALU with valid/ready handshake on both sides.
//            Logic/arithmetic ops take one cycle; shifts iterate one bit per
//            cycle unless ALU_FAST_SHIFT_EN selects a barrel shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_AND  = 4'd3;
    localparam logic [3:0] c_OP_OR   = 4'd4;
    localparam logic [3:0] c_OP_XOR  = 4'd5;
    localparam logic [3:0] c_OP_SLL  = 4'd6;
    localparam logic [3:0] c_OP_SRA  = 4'd7;
    localparam logic [3:0] c_OP_SRL  = 4'd8;
    localparam logic [3:0] c_OP_SLT  = 4'd9;
    localparam logic [3:0] c_OP_SLTU = 4'd10;

    localparam logic [SHW-1:0] c_CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    logic [1:0]      r_state_q,  w_state_d;
    logic [XLEN-1:0] r_result_q, w_result_d;
    logic            r_zero_q,   w_zero_d;
    logic [XLEN-1:0] r_work_q,   w_work_d;
    logic [SHW-1:0]  r_cnt_q,    w_cnt_d;
    logic [3:0]      r_op_q,     w_op_d;

    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu_res;
    logic [XLEN-1:0] w_step;
    logic            w_is_shift;
    logic            w_start_iter;
    logic            w_accept;

    assign w_shamt    = src_b[SHW-1:0];
    assign w_is_shift = (alu_op == c_OP_SLL) || (alu_op == c_OP_SRA) ||
                        (alu_op == c_OP_SRL);
    assign w_accept   = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN
    assign w_start_iter = 1'b0;
`else
    // A zero shift amount completes in one cycle like any other op.
    assign w_start_iter = w_is_shift && (w_shamt != '0);
`endif

    always_comb begin
        w_alu_res = '0;
        case (alu_op)
            c_OP_ADD:  w_alu_res = src_a + src_b;
            c_OP_SUB:  w_alu_res = src_a - src_b;
            c_OP_AND:  w_alu_res = src_a & src_b;
            c_OP_OR:   w_alu_res = src_a | src_b;
            c_OP_XOR:  w_alu_res = src_a ^ src_b;
`ifdef ALU_FAST_SHIFT_EN
            c_OP_SLL:  w_alu_res = src_a << w_shamt;
            c_OP_SRL:  w_alu_res = src_a >> w_shamt;
            c_OP_SRA:  w_alu_res = $unsigned($signed(src_a) >>> w_shamt);
`else
            c_OP_SLL,
            c_OP_SRL,
            c_OP_SRA:  w_alu_res = src_a;
`endif
            c_OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            c_OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            default:   w_alu_res = '0;
        endcase
    end

    // Single-bit step of the iterative shifter.
    always_comb begin
        w_step = r_work_q;
        case (r_op_q)
            c_OP_SLL: w_step = {r_work_q[XLEN-2:0], 1'b0};
            c_OP_SRA: w_step = {r_work_q[XLEN-1], r_work_q[XLEN-1:1]};
            c_OP_SRL: w_step = {1'b0, r_work_q[XLEN-1:1]};
            default:  w_step = r_work_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= c_ST_IDLE;
            r_result_q <= '0;
            r_zero_q   <= 1'b1;
            r_work_q   <= '0;
            r_cnt_q    <= '0;
            r_op_q     <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_result_q <= w_result_d;
            r_zero_q   <= w_zero_d;
            r_work_q   <= w_work_d;
            r_cnt_q    <= w_cnt_d;
            r_op_q     <= w_op_d;
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_result_d = r_result_q;
        w_zero_d   = r_zero_q;
        w_work_d   = r_work_q;
        w_cnt_d    = r_cnt_q;
        w_op_d     = r_op_q;
        case (r_state_q)
            c_ST_IDLE, c_ST_HOLD: begin
                if (w_accept) begin
                    if (w_start_iter) begin
                        w_state_d = c_ST_SHIFT;
                        w_work_d  = src_a;
                        w_cnt_d   = w_shamt;
                        w_op_d    = alu_op;
                    end else begin
                        w_state_d  = c_ST_HOLD;
                        w_result_d = w_alu_res;
                        w_zero_d   = (w_alu_res == '0);
                    end
                end else if ((r_state_q == c_ST_HOLD) && out_ready) begin
                    w_state_d = c_ST_IDLE;
                end
            end
            c_ST_SHIFT: begin
                w_work_d = w_step;
                w_cnt_d  = r_cnt_q - c_CNT_ONE;
                if (r_cnt_q == c_CNT_ONE) begin
                    w_state_d  = c_ST_HOLD;
                    w_result_d = w_step;
                    w_zero_d   = (w_step == '0);
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state_q == c_ST_IDLE) || ((r_state_q == c_ST_HOLD) && out_ready);
        out_valid = (r_state_q == c_ST_HOLD);
`ifdef ALU_FAST_SHIFT_EN
        busy      = 1'b0;
`else
        busy      = (r_state_q == c_ST_SHIFT);
`endif
    end

    assign result = r_result_q;
    assign zero   = r_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Directed self-checking bench for alu_exec_unit (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_vec;
    int n_err;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        src_a    = a;
        src_b    = b;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_op    = 4'd0;
        src_a     = '0;
        src_b     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    result,             32'd0);
        check("rst_zero",      {31'd0, zero},      32'd1);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        rst = 1'b0;

        // ADD 5+3, latency 1
        out_ready = 1'b1;
        issue(4'd1, 32'h0000_0005, 32'h0000_0003);
        tick();
        in_valid = 1'b0;
        check("add_valid",  {31'd0, out_valid}, 32'd1);
        check("add_result", result,             32'h0000_0008);
        check("add_zero",   {31'd0, zero},      32'd0);

        // Back-to-back SUB / SLT / SLTU while HOLD drains
        issue(4'd2, 32'h0000_0007, 32'h0000_0007);
        check("b2b_rdy0", {31'd0, in_ready}, 32'd1);
        tick();
        check("sub_result", result,            32'h0000_0000);
        check("sub_zero",   {31'd0, zero},     32'd1);
        check("sub_valid",  {31'd0, out_valid}, 32'd1);
        issue(4'd9, 32'hFFFF_FFFF, 32'h0000_0001);
        check("b2b_rdy1", {31'd0, in_ready}, 32'd1);
        tick();
        check("slt_result", result,        32'h0000_0001);
        check("slt_zero",   {31'd0, zero}, 32'd0);
        issue(4'd10, 32'hFFFF_FFFF, 32'h0000_0001);
        check("b2b_rdy2", {31'd0, in_ready}, 32'd1);
        tick();
        check("sltu_result", result,            32'h0000_0000);
        check("sltu_zero",   {31'd0, zero},     32'd1);
        check("sltu_valid",  {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("drain_valid",  {31'd0, out_valid}, 32'd0);
        check("drain_result", result,             32'h0000_0000);

        // SRA 0x8000_0000 by 4
        issue(4'd7, 32'h8000_0000, 32'h0000_0004);
        tick();
        in_valid = 1'b0;
`ifndef ALU_FAST_SHIFT_EN
        for (int i = 0; i < 4; i++) begin
            check("sra_busy",  {31'd0, busy},      32'd1);
            check("sra_rdy",   {31'd0, in_ready},  32'd0);
            check("sra_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
`endif
        check("sra_done_valid", {31'd0, out_valid}, 32'd1);
        check("sra_result",     result,             32'hF800_0000);
        check("sra_done_busy",  {31'd0, busy},      32'd0);
        tick();

        // SLL with shift amount 0 (src_b bits above 5 ignored)
        issue(4'd6, 32'h0000_0001, 32'h0000_0020);
        tick();
        in_valid = 1'b0;
        check("sll0_valid",  {31'd0, out_valid}, 32'd1);
        check("sll0_result", result,             32'h0000_0001);
        check("sll0_busy",   {31'd0, busy},      32'd0);
        tick();

        // XOR held with out_ready low, then code 12 accepted as it drains
        out_ready = 1'b0;
        issue(4'd5, 32'hFF00_FF00, 32'h0F0F_0F0F);
        tick();
        issue(4'd12, 32'h1234_5678, 32'h1111_1111);
        check("xor_result", result,            32'hF00F_F00F);
        check("xor_rdy",    {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("xor_hold_result", result,             32'hF00F_F00F);
            check("xor_hold_valid",  {31'd0, out_valid}, 32'd1);
            check("xor_hold_rdy",    {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("xor_rdy_rise", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("op12_result", result,             32'h0000_0000);
        check("op12_zero",   {31'd0, zero},      32'd1);
        check("op12_valid",  {31'd0, out_valid}, 32'd1);
        tick();

        // Reset during the 2nd cycle of SRL by 10
        issue(4'd8, 32'hFFFF_FFFF, 32'h0000_000A);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("abort_valid",  {31'd0, out_valid}, 32'd0);
        check("abort_result", result,             32'h0000_0000);
        check("abort_busy",   {31'd0, busy},      32'd0);
        check("abort_rdy",    {31'd0, in_ready},  32'd1);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort_quiet", {31'd0, out_valid}, 32'd0);
        end
        issue(4'd1, 32'h0000_0010, 32'h0000_0020);
        tick();
        in_valid = 1'b0;
        check("post_add_valid",  {31'd0, out_valid}, 32'd1);
        check("post_add_result", result,             32'h0000_0030);
        check("post_add_zero",   {31'd0, zero},      32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
